fifo_level: RTL and testbench
=============================

Name: fifo_level

Overview:
- Next-generation synchronous FIFO for the UART datapath, sitting between the baud-rate RX/TX engines and the host interface.
- Parametrised in width, depth and watermark thresholds.
- Adds an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush.
- Simultaneous read/write is fully defined at every fill level, including empty and full.

Parameters:
- B, 8, data word width in bits
- W, 4, address width; depth = 2**W entries
- AF_LEVEL, 2**W-2, almost_full asserts when level >= AF_LEVEL (range 1..2**W)
- AE_LEVEL, 2, almost_empty asserts when level <= AE_LEVEL (range 0..2**W-1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- rd  in  1  read request; pops head entry
- wr  in  1  write request; pushes w_data
- w_data  in  B  write data
- clr  in  1  synchronous flush; empties the FIFO and clears error flags
- r_data  out  B  head entry (show-ahead; valid while empty=0)
- empty  out  1  level == 0
- full  out  1  level == 2**W
- almost_empty  out  1  level <= AE_LEVEL
- almost_full  out  1  level >= AF_LEVEL
- level  out  W+1  current occupancy, 0..2**W
- overflow  out  1  sticky: a write was attempted while full
- underflow  out  1  sticky: a read was attempted while empty

Behaviour:
- Reset (reset=0, asynchronous): w_ptr=0, r_ptr=0, level=0, all memory entries=0, overflow=0, underflow=0. Outputs: r_data=0, empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0) (AF_LEVEL>=1, so 0), level=0.
- Reset takes effect immediately, mid-operation included. Any in-flight write is discarded.
- Acceptance is evaluated on registered state at the rising edge:
  - wr_ok = wr & ~full
  - rd_ok = rd & ~empty
- wr_ok: mem[w_ptr] <= w_data; w_ptr <= w_ptr+1, wrapping mod 2**W.
- rd_ok: r_ptr <= r_ptr+1, wrapping mod 2**W.
- level update:
  - +1 if wr_ok & ~rd_ok
  - -1 if rd_ok & ~wr_ok
  - unchanged otherwise
- empty, full, almost_* are combinational compares on registered level. They change in the same cycle as level, one clock after the causing edge.
- r_data = mem[r_ptr] combinationally. Latency: a word written into an empty FIFO appears on r_data the cycle after the write edge, together with empty=0.
- Simultaneous wr & rd:
  - Empty: write accepted, read rejected; underflow set; level becomes 1.
  - Full: read accepted, write rejected; overflow set; level becomes 2**W-1.
  - Otherwise: both accepted, level unchanged, both pointers advance.
- Error flags:
  - overflow <= 1 on wr & full.
  - underflow <= 1 on rd & empty.
  - Both hold until clr or reset. Rejected operations never alter pointers, memory or level.
- clr=1 at an edge: pointers=0, level=0, overflow=0, underflow=0.
  - clr has priority over wr/rd in that cycle; no write is stored and no error is flagged.
  - Memory contents are not cleared; r_data is don't-care while empty.
- Pointer wrap-around is implicit W-bit overflow. Full and empty are disambiguated by level, not by pointer equality.

Decomposition:
- Shared package uart_fifo_pkg:
  - default constants FIFO_B=8, FIFO_W=4
  - localparam helper DEPTH=2**W
- One natural sub-module, fifo_level_ctrl: pointers, level counter, flags and error logic. It outputs w_addr, r_addr and we.
- The register-file array stays in fifo_level so that it can later be swapped for a RAM macro.

Test Plan:
- Reset then fill: with reset=0, expect empty=1, level=0, r_data=0. Release reset and write 0x01..0x10 (16 writes, W=4).
  - level ramps 1..16.
  - almost_empty drops when level becomes 3.
  - almost_full rises at level 14.
  - full=1 at 16.
  - r_data=0x01 throughout.
- Drain in order: from full, assert rd for 16 cycles. r_data sequence is 0x01..0x10, then empty=1 and level=0, with no underflow.
- Boundary collisions:
  - wr=rd=1 with w_data=0xAA while empty: level=1, r_data=0xAA, underflow=1.
  - Refill to full, then wr=rd=1 with w_data=0x55: level=15, overflow=1, and 0x55 is never read back.
- Wrap-around: 40 cycles of continuous wr=rd=1 at level 5 with incrementing data. Level stays 5 and the read stream is the write stream delayed by 5 entries across pointer wrap.
- Flush: at level 9 with overflow=1, pulse clr together with wr=1 and w_data=0x77. Next cycle: level=0, empty=1, overflow=0, underflow=0, and 0x77 is not stored.
- Async reset mid-burst: assert reset between edges during writes at level 7. Outputs go to reset values immediately, with no clock edge needed. After release, a new write of 0x3C reads back as 0x3C.

Source files
------------

// File: rtl/uart_fifo_pkg.sv
// uart_fifo_pkg: shared defaults and depth helper for the UART FIFO blocks
package uart_fifo_pkg;
  localparam int FIFO_B = 8;
  localparam int FIFO_W = 4;
  localparam int FIFO_DEPTH = 2 ** FIFO_W;
  function automatic int fifo_depth(input int w);
    return 2 ** w;
  endfunction
endpackage

// File: rtl/fifo_level_ctrl.sv
// fifo_level_ctrl: pointers, occupancy level, status flags and sticky error flags
// Ports: clk, reset (async active-low), rd/wr requests, clr (sync flush);
//        w_addr/r_addr/we drive the storage array; empty/full/almost_* flags,
//        level (0..2**W), sticky overflow/underflow.
module fifo_level_ctrl
  import uart_fifo_pkg::*;
#(
  parameter int W = FIFO_W,
  parameter int AF_LEVEL = fifo_depth(W) - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd,
  input  logic         wr,
  input  logic         clr,
  output logic [W-1:0] w_addr,
  output logic [W-1:0] r_addr,
  output logic         we,
  output logic         empty,
  output logic         full,
  output logic         almost_empty,
  output logic         almost_full,
  output logic [W:0]   level,
  output logic         overflow,
  output logic         underflow
);
  localparam logic [W:0] FULL_LVL = {1'b1, {W{1'b0}}};
  localparam logic [W:0] AF = AF_LEVEL[W:0];
  localparam logic [W:0] AE = AE_LEVEL[W:0];
  logic rd_ok;
  assign empty = level == '0;
  assign full = level == FULL_LVL;
  assign almost_empty = level <= AE;
  assign almost_full = level >= AF;
  // flush wins over both requests, so neither is accepted in a clr cycle
  assign we = wr & ~full & ~clr;
  assign rd_ok = rd & ~empty & ~clr;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_addr <= '0;
      r_addr <= '0;
      level <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      w_addr <= '0;
      r_addr <= '0;
      level <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (we) w_addr <= w_addr + 1'b1;
      if (rd_ok) r_addr <= r_addr + 1'b1;
      level <= (we & ~rd_ok) ? level + 1'b1 : (rd_ok & ~we) ? level - 1'b1 : level;
      overflow <= overflow | (wr & full);
      underflow <= underflow | (rd & empty);
    end
  end
endmodule

// File: rtl/fifo_level.sv
// fifo_level: synchronous show-ahead FIFO with level count, watermarks and sticky errors
// Ports: clk, reset (async active-low), rd/wr requests, w_data, clr (sync flush);
//        r_data (head entry), empty/full/almost_empty/almost_full, level,
//        overflow/underflow sticky error flags.
module fifo_level
  import uart_fifo_pkg::*;
#(
  parameter int B = FIFO_B,
  parameter int W = FIFO_W,
  parameter int AF_LEVEL = fifo_depth(W) - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  input  logic         clr,
  output logic [B-1:0] r_data,
  output logic         empty,
  output logic         full,
  output logic         almost_empty,
  output logic         almost_full,
  output logic [W:0]   level,
  output logic         overflow,
  output logic         underflow
);
  logic [W-1:0] w_addr, r_addr;
  logic we;
  // storage kept at top level so it can be replaced by a RAM macro
  logic [B-1:0] mem [fifo_depth(W)];
  fifo_level_ctrl #(.W(W), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL)) u_ctrl (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .clr(clr),
    .w_addr(w_addr), .r_addr(r_addr), .we(we),
    .empty(empty), .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
    .level(level), .overflow(overflow), .underflow(underflow)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < fifo_depth(W); i++) mem[i] <= '0;
    end else if (we) begin
      mem[w_addr] <= w_data;
    end
  end
  assign r_data = mem[r_addr];
endmodule

// File: tb/tb_fifo_level.sv
// tb_fifo_level: directed self-checking bench for fifo_level
module tb_fifo_level;
  logic clk, reset, rd, wr, clr;
  logic [7:0] w_data, r_data;
  logic empty, full, almost_empty, almost_full, overflow, underflow;
  logic [4:0] level;
  int total = 0;
  int bad = 0;
  fifo_level dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .w_data(w_data), .clr(clr),
    .r_data(r_data), .empty(empty), .full(full), .almost_empty(almost_empty),
    .almost_full(almost_full), .level(level), .overflow(overflow), .underflow(underflow)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b0; rd = 1'b0; wr = 1'b0; clr = 1'b0; w_data = 8'h00;
    #2;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_rdata", 32'(r_data), 0);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_unf", 32'(underflow), 0);
    step();
    reset = 1'b1;
    step();
    for (int i = 1; i <= 16; i++) begin
      wr = 1'b1; w_data = 8'(i);
      step();
      chk("fill_level", 32'(level), 32'(i));
      chk("fill_rdata", 32'(r_data), 1);
      chk("fill_ae", 32'(almost_empty), 32'(i <= 2));
      chk("fill_af", 32'(almost_full), 32'(i >= 14));
      chk("fill_full", 32'(full), 32'(i == 16));
      chk("fill_empty", 32'(empty), 0);
    end
    wr = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      chk("drain_rdata", 32'(r_data), 32'(i));
      rd = 1'b1;
      step();
      chk("drain_level", 32'(level), 32'(16 - i));
    end
    rd = 1'b0;
    chk("drain_empty", 32'(empty), 1);
    chk("drain_unf", 32'(underflow), 0);
    chk("drain_ovf", 32'(overflow), 0);
    wr = 1'b1; rd = 1'b1; w_data = 8'hAA;
    step();
    wr = 1'b0; rd = 1'b0;
    chk("ce_level", 32'(level), 1);
    chk("ce_rdata", 32'(r_data), 32'h0AA);
    chk("ce_unf", 32'(underflow), 1);
    chk("ce_empty", 32'(empty), 0);
    for (int i = 1; i <= 15; i++) begin
      wr = 1'b1; w_data = 8'(8'h20 + i);
      step();
    end
    chk("refill_level", 32'(level), 16);
    chk("refill_full", 32'(full), 1);
    chk("refill_head", 32'(r_data), 32'h0AA);
    wr = 1'b1; rd = 1'b1; w_data = 8'h55;
    step();
    wr = 1'b0; rd = 1'b0;
    chk("cf_level", 32'(level), 15);
    chk("cf_ovf", 32'(overflow), 1);
    chk("cf_full", 32'(full), 0);
    for (int i = 1; i <= 15; i++) begin
      chk("cf_drain", 32'(r_data), 32'(8'h20 + i));
      rd = 1'b1;
      step();
    end
    rd = 1'b0;
    chk("cf_empty", 32'(empty), 1);
    chk("cf_level0", 32'(level), 0);
    for (int i = 0; i < 5; i++) begin
      wr = 1'b1; w_data = 8'(i);
      step();
    end
    wr = 1'b0;
    chk("wrap_start", 32'(level), 5);
    for (int k = 0; k < 40; k++) begin
      chk("wrap_rdata", 32'(r_data), 32'(k));
      wr = 1'b1; rd = 1'b1; w_data = 8'(k + 5);
      step();
      chk("wrap_level", 32'(level), 5);
    end
    rd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr = 1'b1; w_data = 8'(45 + i);
      step();
    end
    wr = 1'b0;
    chk("pre_flush_level", 32'(level), 9);
    chk("pre_flush_ovf", 32'(overflow), 1);
    chk("pre_flush_head", 32'(r_data), 40);
    clr = 1'b1; wr = 1'b1; w_data = 8'h77;
    step();
    clr = 1'b0; wr = 1'b0;
    chk("flush_level", 32'(level), 0);
    chk("flush_empty", 32'(empty), 1);
    chk("flush_ovf", 32'(overflow), 0);
    chk("flush_unf", 32'(underflow), 0);
    step();
    chk("flush_hold", 32'(level), 0);
    wr = 1'b1; w_data = 8'h11;
    step();
    wr = 1'b0;
    chk("post_flush_rdata", 32'(r_data), 32'h011);
    chk("post_flush_level", 32'(level), 1);
    for (int i = 0; i < 6; i++) begin
      wr = 1'b1; w_data = 8'(8'hC0 + i);
      step();
    end
    chk("burst_level", 32'(level), 7);
    w_data = 8'hE7;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_level", 32'(level), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_rdata", 32'(r_data), 0);
    chk("arst_ae", 32'(almost_empty), 1);
    step();
    wr = 1'b0;
    reset = 1'b1;
    chk("arst_hold", 32'(level), 0);
    wr = 1'b1; w_data = 8'h3C;
    step();
    wr = 1'b0;
    chk("after_rst_rdata", 32'(r_data), 32'h03C);
    chk("after_rst_level", 32'(level), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
